// File: rtl/multdiv_issue_ctrl.sv
// Issue/stall/writeback controller in front of the multdiv unit.
// Optional macro MULTDIV_EXCEPTION_EN redirects faulting/timed-out results to r30 (rstatus).
module multdiv_issue_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [4:0]  rd,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, WB} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [4:0]        rd_q;
  logic              op_mult;
  logic [31:0]       res_q;
  logic              exc_q;
  logic              to_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_q      <= '0;
      op_mult   <= 1'b0;
      res_q     <= '0;
      exc_q     <= 1'b0;
      to_q      <= 1'b0;
      ctrl_mult <= 1'b0;
      ctrl_div  <= 1'b0;
    end else begin
      state     <= state_nxt;
      // Start pulses are high exactly during ISSUE; mult wins a tie.
      ctrl_mult <= (state == IDLE) && start_mult;
      ctrl_div  <= (state == IDLE) && start_div && !start_mult;
      case (state)
        IDLE: if (start_mult || start_div) begin
          rd_q    <= rd;
          op_mult <= start_mult;
        end
        ISSUE: begin
          cnt   <= '0;
          res_q <= '0;
          exc_q <= 1'b0;
          to_q  <= 1'b0;
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (data_resultRDY) begin
            res_q <= data_result;
            exc_q <= data_exception;
          end else if (cnt == CNT_LAST) begin
            res_q <= '0;
            to_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    wb_en     = 1'b0;
    wb_reg    = '0;
    wb_data   = '0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        stall = start_mult | start_div;
        if (start_mult || start_div) state_nxt = ISSUE;
      end
      ISSUE: begin
        stall     = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (data_resultRDY || cnt == CNT_LAST) state_nxt = WB;
      end
      WB: begin
        state_nxt = IDLE;
        timeout   = to_q;
`ifdef MULTDIV_EXCEPTION_EN
        if (exc_q || to_q) begin
          wb_en   = 1'b1;
          wb_reg  = 5'd30;
          wb_data = op_mult ? 32'd4 : 32'd5;
        end else begin
          wb_en   = |rd_q;
          wb_reg  = rd_q;
          wb_data = res_q;
        end
`else
        wb_en   = |rd_q;
        wb_reg  = rd_q;
        wb_data = res_q;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifndef MULTDIV_EXCEPTION_EN
  // Exception flag is captured but has no consumer in this build.
  logic unused_exc;
  assign unused_exc = exc_q;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl; expectations follow MULTDIV_EXCEPTION_EN if defined.
module tb_multdiv_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_mult, start_div;
  logic [4:0]  rd;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;
  logic        ctrl_mult, ctrl_div, stall, wb_en, busy, timeout;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int n_chk  = 0;
  int n_fail = 0;

  multdiv_issue_ctrl #(.TIMEOUT(40), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .rd(rd), .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .stall(stall), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .busy(busy), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one op from IDLE up to the WB cycle (returns at the WB negedge, start still held).
  // delay = cycles after the ctrl pulse at which RDY fires; 0 means never.
  task automatic issue(input logic m, input logic d, input logic [4:0] r, input int delay,
                       input logic [31:0] res, input logic exc,
                       output int mp, output int dp, output int stall_lo, output int wb_k);
    cyc();
    start_mult = m; start_div = d; rd = r;
    #1;
    mp = 0; dp = 0; wb_k = -1;
    stall_lo = stall ? 0 : 1;
    cyc();
    #1;
    mp += int'(ctrl_mult); dp += int'(ctrl_div);
    if (!stall) stall_lo++;
    for (int k = 1; k <= 60; k++) begin
      cyc();
      data_resultRDY = (k == delay);
      data_result    = (k == delay) ? res : 32'hFFFF_FFFF;
      data_exception = (k == delay) ? exc : 1'b1;
      #1;
      mp += int'(ctrl_mult); dp += int'(ctrl_div);
      if (busy && !stall) begin
        wb_k = k;
        break;
      end
      if (!stall) stall_lo++;
    end
    data_resultRDY = 1'b0;
    if (wb_k < 0) chk("wb_reached", 32'd0, 32'd1);
  endtask

  int mp, dp, slo, wk;

  initial begin
    reset = 1'b1; start_mult = 0; start_div = 0; rd = 0;
    data_result = 0; data_exception = 0; data_resultRDY = 0;
    cyc(); cyc();
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ctrl", {ctrl_mult, ctrl_div}, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b0;

    // Mult, RDY 33 cycles after ctrl_mult
    issue(1, 0, 5'd5, 33, 32'h2A, 1'b0, mp, dp, slo, wk);
    chk("mul_ctrl_mult", mp, 1);
    chk("mul_ctrl_div", dp, 0);
    chk("mul_stall_gap", slo, 0);
    chk("mul_latency", wk, 34);
    chk("mul_wb_en", wb_en, 1);
    chk("mul_wb_reg", wb_reg, 5);
    chk("mul_wb_data", wb_data, 32'h2A);
    chk("mul_timeout", timeout, 0);
    start_mult = 0;
    cyc(); #1;
    chk("mul_busy_after", busy, 0);
    chk("mul_wb_en_after", wb_en, 0);

    // Div with exception
    issue(0, 1, 5'd7, 5, 32'hDEAD, 1'b1, mp, dp, slo, wk);
    chk("div_ctrl_div", dp, 1);
    chk("div_ctrl_mult", mp, 0);
    chk("div_wb_en", wb_en, 1);
`ifdef MULTDIV_EXCEPTION_EN
    chk("div_wb_reg", wb_reg, 30);
    chk("div_wb_data", wb_data, 5);
`else
    chk("div_wb_reg", wb_reg, 7);
    chk("div_wb_data", wb_data, 32'hDEAD);
`endif
    start_div = 0;

    // Timeout: no RDY, 40 BUSY cycles
    issue(1, 0, 5'd9, 0, 32'h0, 1'b0, mp, dp, slo, wk);
    chk("to_latency", wk, 41);
    chk("to_flag", timeout, 1);
    chk("to_wb_en", wb_en, 1);
`ifdef MULTDIV_EXCEPTION_EN
    chk("to_wb_reg", wb_reg, 30);
    chk("to_wb_data", wb_data, 4);
`else
    chk("to_wb_reg", wb_reg, 9);
    chk("to_wb_data", wb_data, 0);
`endif
    start_mult = 0;
    cyc(); #1;
    chk("to_flag_after", timeout, 0);

    // Reset at BUSY cycle 10, then a stray RDY
    start_mult = 1; rd = 5'd3;
    cyc();
    repeat (10) cyc();
    #1;
    chk("rstmid_busy_before", busy, 1);
    reset = 1'b1; start_mult = 0;
    cyc(); #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_stall", stall, 0);
    chk("rstmid_ctrl", {ctrl_mult, ctrl_div}, 0);
    reset = 1'b0; data_resultRDY = 1; data_result = 32'h77;
    cyc(); #1;
    data_resultRDY = 0;
    chk("rstmid_wb_en1", wb_en, 0);
    chk("rstmid_busy1", busy, 0);
    cyc(); #1;
    chk("rstmid_wb_en2", wb_en, 0);
    chk("rstmid_busy2", busy, 0);

    // Both starts, rd = r0
    issue(1, 1, 5'd0, 2, 32'h55, 1'b0, mp, dp, slo, wk);
    chk("pri_ctrl_mult", mp, 1);
    chk("pri_ctrl_div", dp, 0);
    chk("pri_latency", wk, 3);
    chk("pri_wb_en", wb_en, 0);

    // Back-to-back: div then mult straight after
    issue(0, 1, 5'd4, 3, 32'h11, 1'b0, mp, dp, slo, wk);
    chk("b2b1_ctrl", {mp[7:0], dp[7:0]}, 16'h0001);
    chk("b2b1_wb_en", wb_en, 1);
    chk("b2b1_wb_reg", wb_reg, 4);
    chk("b2b1_wb_data", wb_data, 32'h11);
    issue(1, 0, 5'd6, 4, 32'h22, 1'b0, mp, dp, slo, wk);
    chk("b2b2_ctrl", {mp[7:0], dp[7:0]}, 16'h0100);
    chk("b2b2_latency", wk, 5);
    chk("b2b2_wb_en", wb_en, 1);
    chk("b2b2_wb_reg", wb_reg, 6);
    chk("b2b2_wb_data", wb_data, 32'h22);
    start_mult = 0;
    cyc(); #1;
    chk("b2b_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
